yc_pattern_gen: RTL

- 15 kHz video timing and test-pattern source; sits directly upstream of the luma/chroma encoder.
- Drives its 24-bit RGB input and its active-high hsync/vsync/csync inputs.
- Counts pixels/lines, generates the syncs, and paints one of four patterns into the active area; blanking area is black.
- All outputs registered so the encoder sees clean, aligned RGB and sync.

---
 rtl/yc_pkg.sv | 27 ++
 rtl/yc_pattern_gen_if.sv | 12 +
 rtl/yc_video_timing.sv | 66 ++++++
 rtl/yc_pattern_gen.sv | 129 ++++++++++++
 4 files changed

// File: rtl/yc_pkg.sv
// rtl/yc_pkg.sv - shared types, timing defaults and bar colours for the YC pattern source
package yc_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_HATCH = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_t;

    // NTSC 240p timing at a 15 kHz line rate
    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 58;
    localparam int DEF_H_TOTAL    = 780;
    localparam int DEF_V_ACTIVE   = 240;
    localparam int DEF_V_FP       = 3;
    localparam int DEF_V_SYNC     = 3;
    localparam int DEF_V_TOTAL    = 262;
    localparam int DEF_RAMP_SHIFT = 2;

    localparam logic [23:0] BAR_COLORS [8] = '{
        24'hC0C0C0, 24'hC0C000, 24'h00C0C0, 24'h00C000,
        24'hC000C0, 24'hC00000, 24'h0000C0, 24'h000000
    };

endpackage

// File: rtl/yc_pattern_gen_if.sv
// rtl/yc_pattern_gen_if.sv - registered RGB plus sync bundle feeding the luma/chroma encoder
interface yc_pattern_gen_if;
    logic [23:0] dout;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        csync;
    logic        frame_start;

    modport master (output dout, de, hsync, vsync, csync, frame_start);
    modport slave  (input  dout, de, hsync, vsync, csync, frame_start);
endinterface

// File: rtl/yc_video_timing.sv
// rtl/yc_video_timing.sv - pixel/line counters with registered syncs, de and frame_start
module yc_video_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 58,
    parameter int H_TOTAL  = 780,
    parameter int V_ACTIVE = 240,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 3,
    parameter int V_TOTAL  = 262
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_pix,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        line_end,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        csync,
    output logic        frame_start
);

    localparam logic [10:0] HA     = 11'(H_ACTIVE);
    localparam logic [10:0] HS_ON  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_OFF = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [9:0]  VA     = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_ON  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

    logic hs_term;
    logic vs_term;

    assign line_end = (hcount == H_LAST);
    assign hs_term  = (hcount >= HS_ON) && (hcount < HS_OFF);
    // vcount only moves on the line wrap, so vsync edges land on line boundaries
    assign vs_term  = (vcount >= VS_ON) && (vcount < VS_OFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount      <= '0;
            vcount      <= '0;
            de          <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            csync       <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce_pix) begin
            de          <= (hcount < HA) && (vcount < VA);
            hsync       <= hs_term;
            vsync       <= vs_term;
            csync       <= hs_term ^ vs_term;
            frame_start <= (hcount == 11'd0) && (vcount == 10'd0);
            if (line_end) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
            end else begin
                hcount <= hcount + 11'd1;
            end
        end
    end

endmodule

// File: rtl/yc_pattern_gen.sv
// rtl/yc_pattern_gen.sv - 15 kHz test-pattern source: frame-latched pattern select and registered RGB
module yc_pattern_gen
    import yc_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_TOTAL    = DEF_H_TOTAL,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_TOTAL    = DEF_V_TOTAL,
    parameter int RAMP_SHIFT = DEF_RAMP_SHIFT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce_pix,
    input  logic [1:0]         pattern_sel,
    input  logic [23:0]        solid_rgb,
    yc_pattern_gen_if.master   vid
);

    if ((H_ACTIVE % 8) != 0 || H_ACTIVE + H_FP + H_SYNC >= H_TOTAL || H_TOTAL > 2047) begin : g_bad_h
        $error("yc_pattern_gen: illegal horizontal timing");
    end
    if (V_ACTIVE + V_FP + V_SYNC >= V_TOTAL || V_TOTAL > 1023) begin : g_bad_v
        $error("yc_pattern_gen: illegal vertical timing");
    end

    localparam logic [10:0] HA       = 11'(H_ACTIVE);
    localparam logic [10:0] HA_LAST  = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  VA       = 10'(V_ACTIVE);
    localparam logic [9:0]  VA_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [7:0]  BAR_LAST = 8'(H_ACTIVE / 8 - 1);

    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        line_end;
    logic        frame_origin;
    logic        active;
    pattern_t    pat_q;
    pattern_t    pat_now;
    logic [23:0] solid_q;
    logic [23:0] solid_now;
    logic [7:0]  bar_cnt;
    logic [2:0]  bar_idx;
    logic [10:0] ramp;
    logic [7:0]  ramp_sat;
    logic [23:0] rgb;

    yc_video_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_TOTAL  (H_TOTAL),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_TOTAL  (V_TOTAL)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .ce_pix      (ce_pix),
        .hcount      (hcount),
        .vcount      (vcount),
        .line_end    (line_end),
        .de          (vid.de),
        .hsync       (vid.hsync),
        .vsync       (vid.vsync),
        .csync       (vid.csync),
        .frame_start (vid.frame_start)
    );

    assign frame_origin = (hcount == 11'd0) && (vcount == 10'd0);
    assign active       = (hcount < HA) && (vcount < VA);
    // the select is live on the origin pixel itself so the new pattern starts exactly at pixel 0, line 0
    assign pat_now      = frame_origin ? pattern_t'(pattern_sel) : pat_q;
    assign solid_now    = frame_origin ? solid_rgb : solid_q;
    assign ramp         = hcount >> RAMP_SHIFT;
    assign ramp_sat     = (ramp[10:8] != 3'd0) ? 8'hFF : ramp[7:0];

    always_comb begin
        rgb = 24'h000000;
        if (active) begin
            case (pat_now)
                PAT_BARS:  rgb = BAR_COLORS[bar_idx];
                PAT_RAMP:  rgb = {ramp_sat, ramp_sat, ramp_sat};
                PAT_HATCH: rgb = (hcount[4:0] == 5'd0 || vcount[4:0] == 5'd0 ||
                                  hcount == HA_LAST || vcount == VA_LAST) ? 24'hFFFFFF : 24'h000000;
                default:   rgb = solid_now;
            endcase
        end
    end

    // bar_cnt/bar_idx track hcount so the bar index needs no divide
    always_ff @(posedge clk) begin
        if (reset) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (ce_pix) begin
            if (line_end) begin
                bar_cnt <= '0;
                bar_idx <= '0;
            end else if (hcount < HA) begin
                if (bar_cnt == BAR_LAST) begin
                    bar_cnt <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_cnt <= bar_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q    <= PAT_BARS;
            solid_q  <= '0;
            vid.dout <= '0;
        end else if (ce_pix) begin
            vid.dout <= rgb;
            if (frame_origin) begin
                pat_q   <= pattern_t'(pattern_sel);
                solid_q <= solid_rgb;
            end
        end
    end

endmodule
